// File: rtl/types_pkg.sv
`default_nettype none
// ============================================================================
// Module   : types_pkg
// Purpose  : Shared types and constants for the display segment shifter.
// Revision : 1.0 - initial parametrised multi-chain release
// ============================================================================
package types_pkg;

    localparam int DISP_BITS   = 256;
    localparam int DISP_CHAINS = 1;

    typedef enum logic [2:0] {
        SR_IDLE  = 3'd0,
        SR_LOAD  = 3'd1,
        SR_SHIFT = 3'd2,
        SR_LATCH = 3'd3,
        SR_GAP   = 3'd4
    } disp_sr_state_e;

    // Counter width for a count range of v, never narrower than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage
`default_nettype wire

// File: rtl/disp_chain_sr.sv
`default_nettype none
// ============================================================================
// Module   : disp_chain_sr
// Purpose  : One driver chain: L-bit parallel-load, MSB-first shift register.
// Revision : 1.0 - initial release
// ============================================================================
module disp_chain_sr #(
    parameter int L = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [L-1:0] data_i,
    output logic         msb_o
);

    logic [L-1:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= data_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end
    end

    assign msb_o = sr_q[L-1];

endmodule
`default_nettype wire

// File: rtl/disp_shift_drv.sv
`default_nettype none
// ============================================================================
// Module   : disp_shift_drv
// Purpose  : Double-buffered multi-chain serialiser for TLC59282 LED drivers.
// Revision : 1.0 - initial parametrised multi-chain release
// ============================================================================
module disp_shift_drv
    import types_pkg::*;
#(
    parameter int BITS     = DISP_BITS,
    parameter int NCHAIN   = DISP_CHAINS,
    parameter int SCLK_DIV = 2,
    parameter int LAT_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_ena,
    input  logic              tsc_1ppms,
    input  logic              force_upd,
    input  logic [BITS-1:0]   disp_data,
    output logic              disp_sclk,
    output logic [NCHAIN-1:0] disp_sin,
    output logic              disp_lat,
    output logic              busy,
    output logic              frame_done
);

    localparam int L     = BITS / NCHAIN;
    localparam int BIT_W = clog2_min1(L);
    localparam int PH_W  = clog2_min1(SCLK_DIV);
    localparam int LC_W  = clog2_min1(LAT_CYC);

    localparam logic [BIT_W-1:0] c_bit_last = BIT_W'(L - 1);
    localparam logic [PH_W-1:0]  c_ph_last  = PH_W'(SCLK_DIV - 1);
    localparam logic [LC_W-1:0]  c_lc_last  = LC_W'(LAT_CYC - 1);

    generate
        if (BITS % NCHAIN != 0) begin : g_chk_bits
            $error("disp_shift_drv: BITS must be divisible by NCHAIN");
        end
        if (SCLK_DIV < 1) begin : g_chk_div
            $error("disp_shift_drv: SCLK_DIV must be >= 1");
        end
        if (LAT_CYC < 1) begin : g_chk_lat
            $error("disp_shift_drv: LAT_CYC must be >= 1");
        end
    endgenerate

    disp_sr_state_e   state_q;
    logic [BIT_W-1:0] bit_q;
    logic [PH_W-1:0]  ph_q;
    logic [LC_W-1:0]  lc_q;
    logic             pend_q;
    logic             sclk_q;
    logic             lat_q;
    logic             busy_q;
    logic             done_q;

    logic              w_trig;
    logic              w_gap_go;
    logic              w_load;
    logic              w_shift;
    logic [NCHAIN-1:0] w_msb;

    always_comb begin
        w_trig   = (tsc_1ppms | force_upd) & disp_ena;
        // A trigger arriving in the GAP cycle is honoured by that same decision.
        w_gap_go = (state_q == SR_GAP) && disp_ena && (pend_q || w_trig);
        w_load   = ((state_q == SR_IDLE) && w_trig) || w_gap_go;
        w_shift  = (state_q == SR_SHIFT) && (ph_q == c_ph_last) && sclk_q
                   && (bit_q != c_bit_last);
    end

    generate
        for (genvar k = 0; k < NCHAIN; k++) begin : g_chain
            disp_chain_sr #(
                .L(L)
            ) u_chain (
                .clk     (clk),
                .rst_n   (rst_n),
                .load_i  (w_load),
                .shift_i (w_shift),
                .data_i  (disp_data[(k+1)*L-1 -: L]),
                .msb_o   (w_msb[k])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SR_IDLE;
            bit_q   <= '0;
            ph_q    <= '0;
            lc_q    <= '0;
            pend_q  <= 1'b0;
            sclk_q  <= 1'b0;
            lat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (!disp_ena) begin
                pend_q <= 1'b0;
            end else if (w_trig && (state_q != SR_IDLE) && (state_q != SR_GAP)) begin
                pend_q <= 1'b1;
            end

            case (state_q)
                SR_IDLE: begin
                    if (w_trig) begin
                        state_q <= SR_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                SR_LOAD: begin
                    state_q <= SR_SHIFT;
                    bit_q   <= '0;
                    ph_q    <= '0;
                    sclk_q  <= 1'b0;
                end
                SR_SHIFT: begin
                    if (ph_q == c_ph_last) begin
                        ph_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == c_bit_last) begin
                                state_q <= SR_LATCH;
                                lat_q   <= 1'b1;
                                lc_q    <= '0;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end else begin
                        ph_q <= ph_q + PH_W'(1);
                    end
                end
                SR_LATCH: begin
                    if (lc_q == c_lc_last) begin
                        lat_q   <= 1'b0;
                        state_q <= SR_GAP;
                        done_q  <= 1'b1;
                    end else begin
                        lc_q <= lc_q + LC_W'(1);
                    end
                end
                SR_GAP: begin
                    pend_q <= 1'b0;
                    if (w_gap_go) begin
                        state_q <= SR_LOAD;
                    end else begin
                        state_q <= SR_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= SR_IDLE;
                    busy_q  <= 1'b0;
                    sclk_q  <= 1'b0;
                    lat_q   <= 1'b0;
                end
            endcase
        end
    end

    assign disp_sclk  = sclk_q;
    assign disp_lat   = lat_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign disp_sin   = ((state_q == SR_LOAD) || (state_q == SR_SHIFT)) ? w_msb
                                                                        : '0;

endmodule
`default_nettype wire

// File: tb/tb_disp_shift_drv.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_shift_drv
// Purpose  : Directed self-checking bench for disp_shift_drv (two configs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_shift_drv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: BITS=16, NCHAIN=2, SCLK_DIV=1, LAT_CYC=2
    logic        ena_a = 1'b0, tsc_a = 1'b0, frc_a = 1'b0;
    logic [15:0] data_a = '0;
    logic        sclk_a, lat_a, busy_a, done_a;
    logic [1:0]  sin_a;

    disp_shift_drv #(.BITS(16), .NCHAIN(2), .SCLK_DIV(1), .LAT_CYC(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .disp_ena(ena_a), .tsc_1ppms(tsc_a),
        .force_upd(frc_a), .disp_data(data_a), .disp_sclk(sclk_a),
        .disp_sin(sin_a), .disp_lat(lat_a), .busy(busy_a), .frame_done(done_a)
    );

    // Instance B: default configuration
    logic         ena_b = 1'b0, tsc_b = 1'b0, frc_b = 1'b0;
    logic [255:0] data_b = '0;
    logic         sclk_b, lat_b, busy_b, done_b;
    logic [0:0]   sin_b;

    disp_shift_drv u_dut_b (
        .clk(clk), .rst_n(rst_n), .disp_ena(ena_b), .tsc_1ppms(tsc_b),
        .force_upd(frc_b), .disp_data(data_b), .disp_sclk(sclk_b),
        .disp_sin(sin_b), .disp_lat(lat_b), .busy(busy_b), .frame_done(done_b)
    );

    // Monitors: cumulative logs, read by the test as deltas.
    logic       prev_sclk_a = 1'b0, prev_lat_a = 1'b0;
    int         edges_a = 0, lat_cnt_a = 0, lat_rise_a = 0;
    int         done_n_a = 0, done_last_a = 0, done_prev_a = 0;
    logic [7:0] cap1 = '0, cap0 = '0;

    always @(negedge clk) begin
        if (sclk_a && !prev_sclk_a) begin
            edges_a <= edges_a + 1;
            cap1    <= {cap1[6:0], sin_a[1]};
            cap0    <= {cap0[6:0], sin_a[0]};
        end
        if (lat_a && !prev_lat_a) lat_rise_a <= cyc;
        if (lat_a) lat_cnt_a <= lat_cnt_a + 1;
        if (done_a) begin
            done_n_a    <= done_n_a + 1;
            done_prev_a <= done_last_a;
            done_last_a <= cyc;
        end
        prev_sclk_a <= sclk_a;
        prev_lat_a  <= lat_a;
    end

    logic         prev_sclk_b = 1'b0;
    int           edges_b = 0, done_n_b = 0, done_last_b = 0;
    logic [255:0] capb = '0;

    always @(negedge clk) begin
        if (sclk_b && !prev_sclk_b) begin
            edges_b <= edges_b + 1;
            capb    <= {capb[254:0], sin_b[0]};
        end
        if (done_b) begin
            done_n_b    <= done_n_b + 1;
            done_last_b <= cyc;
        end
        prev_sclk_b <= sclk_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_a(input bit use_force, output int t);
        @(posedge clk); #1;
        if (use_force) frc_a = 1'b1; else tsc_a = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        frc_a = 1'b0;
        tsc_a = 1'b0;
    endtask

    task automatic wait_done_a(input int target, input int budget, input string nm);
        int k = 0;
        while (done_n_a < target && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk({nm, "_timeout"}, (done_n_a >= target) ? 1 : 0, 1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] data;
        logic [7:0]  exp1;
        logic [7:0]  exp0;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int t, e0, l0, n0, k;

        vecs[0] = '{16'hA5C3, 8'hA5, 8'hC3};
        vecs[1] = '{16'hFFFF, 8'hFF, 8'hFF};
        vecs[2] = '{16'h0000, 8'h00, 8'h00};
        vecs[3] = '{16'h8001, 8'h80, 8'h01};
        vecs[4] = '{16'h1234, 8'h12, 8'h34};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sclk_a", sclk_a, 0);
        chk("rst_lat_a",  lat_a,  0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_sin_a",  sin_a,  0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;
        ena_a = 1'b1;
        ena_b = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames
        foreach (vecs[i]) begin
            data_a = vecs[i].data;
            e0 = edges_a; l0 = lat_cnt_a; n0 = done_n_a;
            pulse_a(1'b0, t);
            wait_done_a(n0 + 1, 100, "vec");
            chk($sformatf("vec%0d_edges", i), edges_a - e0, 8);
            chk($sformatf("vec%0d_sin1", i), cap1, vecs[i].exp1);
            chk($sformatf("vec%0d_sin0", i), cap0, vecs[i].exp0);
            chk($sformatf("vec%0d_lat_rise", i), lat_rise_a - t, 18);
            chk($sformatf("vec%0d_lat_len", i), lat_cnt_a - l0, 2);
            chk($sformatf("vec%0d_done_at", i), done_last_a - t, 20);
            chk($sformatf("vec%0d_done_cnt", i), done_n_a - n0, 1);
            chk($sformatf("vec%0d_idle", i), busy_a, 0);
        end

        // Double buffer: data change mid-SHIFT must not tear the frame
        data_a = 16'hA5C3;
        e0 = edges_a; n0 = done_n_a;
        pulse_a(1'b0, t);
        k = 0;
        while (edges_a - e0 < 3 && k < 50) begin
            @(negedge clk); #1; k++;
        end
        data_a = 16'hFFFF;
        wait_done_a(n0 + 1, 100, "dbuf1");
        chk("dbuf_sin1", cap1, 8'hA5);
        chk("dbuf_sin0", cap0, 8'hC3);
        n0 = done_n_a;
        pulse_a(1'b0, t);
        wait_done_a(n0 + 1, 100, "dbuf2");
        chk("dbuf_next_sin1", cap1, 8'hFF);
        chk("dbuf_next_sin0", cap0, 8'hFF);

        // Queue: three software triggers during a frame yield one follow-on
        data_a = 16'h1234;
        e0 = edges_a; n0 = done_n_a;
        pulse_a(1'b0, t);
        for (int j = 0; j < 3; j++) begin
            repeat (2) @(posedge clk);
            pulse_a(1'b1, k);
        end
        wait_done_a(n0 + 2, 150, "queue");
        repeat (30) @(negedge clk);
        #1;
        chk("queue_done_cnt", done_n_a - n0, 2);
        chk("queue_back2back", done_last_a - done_prev_a, 20);
        chk("queue_edges", edges_a - e0, 16);
        chk("queue_sin1", cap1, 8'h12);
        chk("queue_sin0", cap0, 8'h34);

        // Enable gating: drop enable mid-SHIFT with a trigger pending
        data_a = 16'h8001;
        e0 = edges_a; l0 = lat_cnt_a; n0 = done_n_a;
        pulse_a(1'b0, t);
        repeat (2) @(posedge clk);
        pulse_a(1'b1, k);
        @(posedge clk); #1;
        ena_a = 1'b0;
        wait_done_a(n0 + 1, 100, "ena");
        repeat (30) @(negedge clk);
        #1;
        chk("ena_done_cnt", done_n_a - n0, 1);
        chk("ena_lat_len", lat_cnt_a - l0, 2);
        chk("ena_edges", edges_a - e0, 8);
        e0 = edges_a;
        pulse_a(1'b0, t);
        pulse_a(1'b1, t);
        repeat (10) @(negedge clk);
        #1;
        chk("ena_off_edges", edges_a - e0, 0);
        chk("ena_off_busy", busy_a, 0);
        ena_a = 1'b1;

        // Asynchronous reset during LATCH
        data_a = 16'h5AF0;
        pulse_a(1'b0, t);
        k = 0;
        while (!lat_a && k < 40) begin
            @(negedge clk); #1; k++;
        end
        chk("rstmid_reached_latch", lat_a, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_lat", lat_a, 0);
        chk("rstmid_sclk", sclk_a, 0);
        chk("rstmid_busy", busy_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rstmid_idle", busy_a, 0);
        e0 = edges_a; l0 = lat_cnt_a; n0 = done_n_a;
        pulse_a(1'b0, t);
        wait_done_a(n0 + 1, 100, "rstmid");
        chk("rstmid_edges", edges_a - e0, 8);
        chk("rstmid_sin1", cap1, 8'h5A);
        chk("rstmid_sin0", cap0, 8'hF0);
        chk("rstmid_lat_len", lat_cnt_a - l0, 2);
        chk("rstmid_done_at", done_last_a - t, 20);

        // Default configuration frame
        data_b = {16{16'hA5C3}};
        e0 = edges_b; n0 = done_n_b;
        @(posedge clk); #1;
        tsc_b = 1'b1;
        t = cyc;
        @(posedge clk); #1;
        tsc_b = 1'b0;
        k = 0;
        while (done_n_b < n0 + 1 && k < 1200) begin
            @(negedge clk); #1; k++;
        end
        chk("def_timeout", (done_n_b >= n0 + 1) ? 1 : 0, 1);
        chk("def_edges", edges_b - e0, 256);
        chk("def_done_at", done_last_b - t, 1028);
        chk("def_data", (capb == {16{16'hA5C3}}) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
